// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two-requester arbiter in front of a registered shift-add multiplier
// Optional MULT_ARBITER_FIXED_PRIO_EN: requester 0 always wins a tie instead of round-robin.
`timescale 1ns/1ps

module mult_arbiter #(
   parameter int p_width = 4
) (
   input  logic                 i_w_clk,
   input  logic                 i_w_rst_n,
   input  logic                 i_w_req0,
   input  logic                 i_w_req1,
   input  logic [p_width-1:0]   i_w_a0,
   input  logic [p_width-1:0]   i_w_b0,
   input  logic [p_width-1:0]   i_w_a1,
   input  logic [p_width-1:0]   i_w_b1,
   output logic [2*p_width-1:0] o_r_p,
   output logic                 o_r_valid,
   output logic                 o_r_id,
   output logic                 o_r_busy
);

   localparam int p_pw = 2 * p_width;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic               take;
   logic               pick1;
   logic               last_q;
   logic               id_q;
   logic [p_width-1:0] a_q;
   logic [p_width-1:0] b_q;
   logic [p_pw-1:0]    prod;

`ifdef MULT_ARBITER_FIXED_PRIO_EN
   assign pick1 = i_w_req1 & ~i_w_req0;
`else
   // On a tie requester 1 wins only if requester 0 was granted last.
   assign pick1 = i_w_req1 & (~i_w_req0 | ~last_q);
`endif

   always_comb begin
      prod = '0;
      for (int i = 0; i < p_width; i++) begin
         if (b_q[i]) begin
            prod = prod + ({{p_width{1'b0}}, a_q} << i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_w_req0 | i_w_req1) begin
               take    = 1'b1;
               state_d = CALC;
            end
         end
         CALC:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
      if (!i_w_rst_n) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         id_q      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         o_r_p     <= '0;
         o_r_valid <= 1'b0;
         o_r_id    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (take) begin
            a_q    <= pick1 ? i_w_a1 : i_w_a0;
            b_q    <= pick1 ? i_w_b1 : i_w_b0;
            id_q   <= pick1;
            last_q <= pick1;
         end
         if (state_q == CALC) begin
            o_r_p     <= prod;
            o_r_id    <= id_q;
            o_r_valid <= 1'b1;
         end else begin
            o_r_valid <= 1'b0;
         end
      end
   end

   assign o_r_busy = (state_q != IDLE);

endmodule
